// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM states, request payload.
package mem_access_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [SIZE_W-1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Latched request; sgn already masked to 0 for stores so it can drive mem_s directly
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              sgn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Number of bytes touched by an access of the given size (0 for the illegal code)
    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_WORD: size_bytes = 3'd4;
            SZ_HALF: size_bytes = 3'd2;
            SZ_BYTE: size_bytes = 3'd1;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Sign/zero extension of raw load data according to access size.
module mem_access_ctrl_load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [SIZE_W-1:0] size_i,
    input  logic              sgn_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_c
);

    // Extend half/byte loads; word (and the never-used illegal code) pass through
    always_comb begin
        dout_c = din_i;
        case (size_e'(size_i))
            SZ_HALF: dout_c = {{16{sgn_i & din_i[15]}}, din_i[15:0]};
            SZ_BYTE: dout_c = {{24{sgn_i & din_i[7]}}, din_i[7:0]};
            default: dout_c = din_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the byte-addressed data memory: one request at a time,
// checks size/alignment/range, strobes memory for MEM_LAT cycles, returns a response.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned ADDR_LIMIT = 1024,
    parameter int unsigned ALIGN_CHK  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_w,
    output logic              mem_r,
    output logic              mem_s,
    output logic [SIZE_W-1:0] mem_c,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              mem_r_q, mem_r_d;
    logic              mem_w_q, mem_w_d;

    size_e             in_size_c;
    logic              size_err_c;
    logic              align_err_c;
    logic              range_err_c;
    logic [ADDR_W:0]   end_addr_c;
    logic [DATA_W-1:0] ext_rdata_c;

    // Request legality: illegal size, misalignment, or any byte beyond ADDR_LIMIT (33-bit sum)
    always_comb begin
        in_size_c   = size_e'(req_size);
        size_err_c  = (in_size_c == SZ_BAD);
        align_err_c = (ALIGN_CHK != 0) &&
                      (((in_size_c == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                       ((in_size_c == SZ_HALF) && req_addr[0]));
        end_addr_c  = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(in_size_c));
        range_err_c = end_addr_c > (ADDR_W+1)'(ADDR_LIMIT);
    end

    mem_access_ctrl_load_extend u_load_extend (
        .size_i (req_q.size),
        .sgn_i  (req_q.sgn),
        .din_i  (mem_rdata),
        .dout_c (ext_rdata_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.we    = req_we;
                    req_d.size  = in_size_c;
                    req_d.sgn   = req_signed & ~req_we;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    rdata_d     = '0;
                    if (size_err_c || align_err_c || range_err_c) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = req_q.we ? '0 : ext_rdata_c;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        mem_r_d     = (state_d == ST_ACCESS) && !req_d.we;
        mem_w_d     = (state_d == ST_ACCESS) && req_d.we;
    end

    // State and output registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_r     = mem_r_q;
    assign mem_w     = mem_w_q;
    assign mem_s     = req_q.sgn;
    assign mem_c     = req_q.size;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: instance a (MEM_LAT=1) and instance b (MEM_LAT=3) share request data inputs.
module tb_mem_access_ctrl;

    logic        clk;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_rdata;

    logic        a_rst_n, a_req_valid, a_rsp_ready;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_w, a_mem_r, a_mem_s;
    logic [1:0]  a_mem_c;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;

    logic        b_rst_n, b_req_valid, b_rsp_ready;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_w, b_mem_r, b_mem_s;
    logic [1:0]  b_mem_c;
    logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(1), .ADDR_LIMIT(1024), .ALIGN_CHK(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_w(a_mem_w), .mem_r(a_mem_r), .mem_s(a_mem_s), .mem_c(a_mem_c),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.MEM_LAT(3), .ADDR_LIMIT(1024), .ALIGN_CHK(1)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_w(b_mem_w), .mem_r(b_mem_r), .mem_s(b_mem_s), .mem_c(b_mem_c),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
    );

    // One comparison: count it, and on mismatch count and report it
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Full request/response on instance a (MEM_LAT=1, rsp_ready held 1); starts and ends in IDLE at a negedge
    task automatic req_a(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input logic exp_err, input logic [31:0] exp_rdata);
        req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        mem_rdata = rd;
        a_req_valid = 1'b1;
        check({tag, ".ready"}, a_req_ready, 1);
        @(negedge clk);
        a_req_valid = 1'b0;
        if (!exp_err) begin
            check({tag, ".strobe"}, {a_mem_w, a_mem_r}, {we, ~we});
            check({tag, ".addr"}, a_mem_addr, addr);
            check({tag, ".c"}, a_mem_c, sz);
            check({tag, ".s"}, a_mem_s, sg & ~we);
            check({tag, ".wdata"}, a_mem_wdata, wd);
            check({tag, ".early"}, a_rsp_valid, 0);
            @(negedge clk);
        end
        check({tag, ".valid"}, a_rsp_valid, 1);
        check({tag, ".err"}, a_rsp_err, exp_err);
        check({tag, ".rdata"}, a_rsp_rdata, exp_rdata);
        check({tag, ".nostrobe"}, {a_mem_w, a_mem_r}, 0);
        @(negedge clk);
        check({tag, ".idle"}, {a_rsp_valid, a_req_ready}, 2'b01);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst.a_ready", a_req_ready, 0);
        check("rst.a_valid", a_rsp_valid, 0);
        check("rst.a_strobes", {a_mem_w, a_mem_r, a_mem_s}, 0);
        check("rst.a_addr", a_mem_addr, 0);
        check("rst.a_rdata", a_rsp_rdata, 0);
        check("rst.b_wdata", b_mem_wdata, 0);
        check("rst.b_ready", b_req_ready, 0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        check("rel.a_ready_low", a_req_ready, 0);
        @(negedge clk);
        check("rel.a_ready", a_req_ready, 1);
        check("rel.b_ready", b_req_ready, 1);

        // Store then load word
        req_a("st_w10",  1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0);
        req_a("ld_w10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        // Half extension
        req_a("ld_hs",   1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_8001, 1'b0, 32'hFFFF8001);
        req_a("ld_hu",   1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h0000_8001, 1'b0, 32'h00008001);
        // Byte extension
        req_a("ld_bs7f", 1'b0, 2'b10, 1'b1, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 32'h0000007F);
        req_a("ld_bs80", 1'b0, 2'b10, 1'b1, 32'h21, 32'h0, 32'h0000_0080, 1'b0, 32'hFFFFFF80);
        req_a("ld_bu80", 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'hFFFF_FF80, 1'b0, 32'h00000080);
        // Errors: misaligned, illegal size, out of range
        req_a("e_ldw2",  1'b0, 2'b00, 1'b0, 32'h2,   32'h0,  32'h1234_5678, 1'b1, 32'h0);
        req_a("e_sth3",  1'b1, 2'b01, 1'b0, 32'h3,   32'h55, 32'h1234_5678, 1'b1, 32'h0);
        req_a("e_size",  1'b0, 2'b11, 1'b0, 32'h0,   32'h0,  32'h1234_5678, 1'b1, 32'h0);
        req_a("e_w3fe",  1'b0, 2'b00, 1'b0, 32'h3FE, 32'h0,  32'h1234_5678, 1'b1, 32'h0);
        req_a("e_b400",  1'b0, 2'b10, 1'b0, 32'h400, 32'h0,  32'h1234_5678, 1'b1, 32'h0);
        req_a("e_wwrap", 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 1'b1, 32'h0);
        // Last legal bytes of memory
        req_a("ok_w3fc", 1'b0, 2'b00, 1'b0, 32'h3FC, 32'h0, 32'hA5A5_0001, 1'b0, 32'hA5A50001);
        req_a("ok_h3fe", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 32'hFFFF_7FFF, 1'b0, 32'h00007FFF);
        req_a("ok_sb3ff",1'b1, 2'b10, 1'b0, 32'h3FF, 32'hAB, 32'h0,        1'b0, 32'h0);

        // MEM_LAT=3 with response back-pressure and req_valid held high throughout
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h40;
        mem_rdata = 32'h1234_5678;
        b_req_valid = 1'b1; b_rsp_ready = 1'b0;
        check("bp.ready", b_req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) req_addr = 32'h80;
            check("bp.mem_r", b_mem_r, 1);
            check("bp.acc_ready", b_req_ready, 0);
            check("bp.acc_addr", b_mem_addr, 32'h40);
            check("bp.acc_valid", b_rsp_valid, 0);
        end
        @(negedge clk);
        mem_rdata = 32'hFFFF_FFFF;
        check("bp.mem_r_off", b_mem_r, 0);
        check("bp.valid", b_rsp_valid, 1);
        check("bp.rdata", b_rsp_rdata, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_valid", b_rsp_valid, 1);
            check("bp.hold_rdata", b_rsp_rdata, 32'h1234_5678);
            check("bp.hold_err", b_rsp_err, 0);
            check("bp.hold_ready", b_req_ready, 0);
            check("bp.hold_mem", {b_mem_w, b_mem_r, b_mem_s, b_mem_c}, 0);
            check("bp.hold_addr", b_mem_addr, 32'h40);
        end
        b_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.done_valid", b_rsp_valid, 0);
        check("bp.done_ready", b_req_ready, 1);
        b_req_valid = 1'b0; b_rsp_ready = 1'b0;
        @(negedge clk);
        check("bp.idle", {b_rsp_valid, b_mem_r, b_req_ready}, 3'b001);

        // Reset in the 2nd ACCESS cycle drops the access
        b_rsp_ready = 1'b1;
        req_addr = 32'h44; mem_rdata = 32'h0BAD_F00D;
        b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        check("ra.acc1", b_mem_r, 1);
        @(negedge clk);
        check("ra.acc2", b_mem_r, 1);
        b_rst_n = 1'b0;
        #1;
        check("ra.mem_r_drop", b_mem_r, 0);
        check("ra.ready_low", b_req_ready, 0);
        check("ra.valid_low", b_rsp_valid, 0);
        @(negedge clk);
        b_rst_n = 1'b1;
        check("ra.rel_ready", b_req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ra.no_rsp", b_rsp_valid, 0);
            check("ra.ready", b_req_ready, 1);
            check("ra.no_strobe", {b_mem_w, b_mem_r}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
